// File: rtl/arb_mux2.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// arb_mux2
//
// Packet-aware round-robin arbiter for two valid/ready stream channels
// (A and B) feeding a single registered output stage. A grant is held from
// the first beat of a packet through its last beat. The output carries the
// source index alongside every beat so a downstream 2:1 select stage knows
// where each beat came from.
//
// Parameters:
//   W        data width of every channel
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   a_valid  channel A beat present
//   a_data   channel A payload
//   a_last   channel A end-of-packet marker
//   a_ready  channel A beat accepted this cycle (combinational)
//   b_valid  channel B beat present
//   b_data   channel B payload
//   b_last   channel B end-of-packet marker
//   b_ready  channel B beat accepted this cycle (combinational)
//   y_valid  output beat present (registered)
//   y_data   output payload (registered)
//   y_last   output end-of-packet marker (registered)
//   y_ready  downstream accepts the current output beat
//   s        source of the current output beat, 0 = A, 1 = B (registered)
// ---------------------------------------------------------------------------
module arb_mux2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  output logic         y_last,
  input  logic         y_ready,
  output logic         s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic           pref_reg, pref_next;
  logic           y_valid_reg, y_valid_next;
  logic [W-1:0]   y_data_reg, y_data_next;
  logic           y_last_reg, y_last_next;
  logic           s_reg, s_next;

  logic           free;
  logic           grant_en;
  logic           grant_sel;
  logic           sel_valid;
  logic [W-1:0]   sel_data;
  logic           sel_last;
  logic           xfer;

  // The output slot can take a new beat when it is empty or being drained
  // this very cycle, which is what gives full throughput with no bubbles.
  assign free = !y_valid_reg || y_ready;

  // Grant selection. While locked the owner keeps the grant even if it has
  // dropped valid; the other channel simply waits. In IDLE the grant is
  // decided from the current valids, so a new packet can start in the same
  // cycle the previous owner's last beat has moved the state back to IDLE.
  always_comb begin
    grant_en  = 1'b0;
    grant_sel = 1'b0;
    case (state_reg)
      LOCK_A: begin
        grant_en  = 1'b1;
        grant_sel = 1'b0;
      end
      LOCK_B: begin
        grant_en  = 1'b1;
        grant_sel = 1'b1;
      end
      default: begin
        if (a_valid && b_valid) begin
          grant_en  = 1'b1;
          grant_sel = pref_reg;
        end else if (a_valid) begin
          grant_en  = 1'b1;
          grant_sel = 1'b0;
        end else if (b_valid) begin
          grant_en  = 1'b1;
          grant_sel = 1'b1;
        end
      end
    endcase
  end

  // Mux of the granted channel's beat.
  assign sel_valid = grant_sel ? b_valid : a_valid;
  assign sel_data  = grant_sel ? b_data  : a_data;
  assign sel_last  = grant_sel ? b_last  : a_last;

  // Readies are gated by rst so nothing upstream sees an acceptance while
  // the registers are being held in reset.
  assign a_ready = !rst && free && grant_en && !grant_sel;
  assign b_ready = !rst && free && grant_en &&  grant_sel;
  assign xfer    = !rst && free && grant_en && sel_valid;

  // Next-state and output register update.
  always_comb begin
    state_next   = state_reg;
    pref_next    = pref_reg;
    y_valid_next = y_valid_reg;
    y_data_next  = y_data_reg;
    y_last_next  = y_last_reg;
    s_next       = s_reg;

    if (xfer) begin
      y_valid_next = 1'b1;
      y_data_next  = sel_data;
      y_last_next  = sel_last;
      s_next       = grant_sel;
      if (sel_last) begin
        // Packet done: release the lock and hand priority to the other side.
        state_next = IDLE;
        pref_next  = !grant_sel;
      end else begin
        state_next = grant_sel ? LOCK_B : LOCK_A;
      end
    end else if (y_valid_reg && y_ready) begin
      // Beat drained with nothing to replace it; payload and source are kept.
      y_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pref_reg    <= 1'b0;
      y_valid_reg <= 1'b0;
      y_data_reg  <= '0;
      y_last_reg  <= 1'b0;
      s_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pref_reg    <= pref_next;
      y_valid_reg <= y_valid_next;
      y_data_reg  <= y_data_next;
      y_last_reg  <= y_last_next;
      s_reg       <= s_next;
    end
  end

  assign y_valid = y_valid_reg;
  assign y_data  = y_data_reg;
  assign y_last  = y_last_reg;
  assign s       = s_reg;

endmodule

// File: tb/tb_arb_mux2.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_arb_mux2
//
// Self-checking bench for arb_mux2. Per-channel packet sources replay queued
// beats while honouring valid/ready. A behavioural model tracks the current
// packet owner, the round-robin preference and the output slot, and one
// compare process checks every DUT output against it on each falling edge.
// Per-channel scoreboards confirm that every accepted beat leaves in order
// and that packets never interleave. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_arb_mux2;
  localparam int W = 8;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         a_valid = 1'b0;
  logic [W-1:0] a_data  = '0;
  logic         a_last  = 1'b0;
  logic         a_ready;
  logic         b_valid = 1'b0;
  logic [W-1:0] b_data  = '0;
  logic         b_last  = 1'b0;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_last;
  logic         y_ready = 1'b1;
  logic         s;

  always #5 clk = ~clk;

  arb_mux2 #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_ready (y_ready),
    .s       (s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet sources ----------------
  typedef struct packed {
    logic [7:0]   gap;   // idle cycles before this beat is offered
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  logic  a_acc = 1'b0;
  logic  b_acc = 1'b0;
  logic  flush_req = 1'b0;
  int    a_wait = 0;
  int    b_wait = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (flush_req) begin
        qa.delete(); a_valid = 1'b0; a_wait = 0;
      end else begin
        if (a_acc) begin
          void'(qa.pop_front());
          a_valid = 1'b0;
        end
        if (!a_valid && qa.size() > 0) begin
          if (a_wait < int'(qa[0].gap)) a_wait++;
          else begin
            a_valid = 1'b1; a_data = qa[0].data; a_last = qa[0].last; a_wait = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (flush_req) begin
        qb.delete(); b_valid = 1'b0; b_wait = 0;
      end else begin
        if (b_acc) begin
          void'(qb.pop_front());
          b_valid = 1'b0;
        end
        if (!b_valid && qb.size() > 0) begin
          if (b_wait < int'(qb[0].gap)) b_wait++;
          else begin
            b_valid = 1'b1; b_data = qb[0].data; b_last = qb[0].last; b_wait = 0;
          end
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_owner: channel holding the packet lock, or -1 when no packet is open.
  int           m_owner = -1;
  bit           m_pref  = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  bit           m_last  = 1'b0;
  bit           m_s     = 1'b0;

  function automatic int m_grant();
    if (m_owner >= 0)         return m_owner;
    if (a_valid && b_valid)   return int'(m_pref);
    if (a_valid)              return 0;
    if (b_valid)              return 1;
    return -1;
  endfunction

  function automatic bit m_free();
    return !m_valid || y_ready;
  endfunction

  function automatic bit m_xfer();
    int g = m_grant();
    if (g < 0) return 1'b0;
    return m_free() && ((g == 0) ? a_valid : b_valid);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_pref <= 1'b0; m_valid <= 1'b0;
      m_data  <= '0; m_last <= 1'b0; m_s     <= 1'b0;
    end else if (m_xfer()) begin
      m_valid <= 1'b1;
      if (m_grant() == 0) begin
        m_data <= a_data; m_last <= a_last; m_s <= 1'b0;
      end else begin
        m_data <= b_data; m_last <= b_last; m_s <= 1'b1;
      end
      if ((m_grant() == 0) ? a_last : b_last) begin
        m_owner <= -1;
        m_pref  <= (m_grant() == 0);
      end else begin
        m_owner <= m_grant();
      end
    end else if (m_valid && y_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic [W:0] sb_a[$];          // {last, data} accepted on A, not yet output
  logic [W:0] sb_b[$];
  logic [9:0] out_log[$];       // {s, last, data} of every output handshake
  int         out_cyc[$];
  int         cyc = 0;
  logic       out_open = 1'b0;
  logic       out_src  = 1'b0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    a_acc <= a_valid && a_ready;
    b_acc <= b_valid && b_ready;

    check("y_valid", 32'(y_valid), 32'(m_valid));
    check("y_data",  32'(y_data),  32'(m_data));
    check("y_last",  32'(y_last),  32'(m_last));
    check("s",       32'(s),       32'(m_s));
    check("a_ready", 32'(a_ready), 32'(!rst && m_free() && m_grant() == 0));
    check("b_ready", 32'(b_ready), 32'(!rst && m_free() && m_grant() == 1));

    if (rst) begin
      sb_a.delete(); sb_b.delete();
      out_open <= 1'b0;
    end else begin
      if (y_valid && y_ready) begin
        out_log.push_back({s, y_last, y_data});
        out_cyc.push_back(cyc);
        if (s == 1'b0) begin
          check("sb_a_nonempty", 32'(sb_a.size() > 0), 32'd1);
          if (sb_a.size() > 0) check("sb_a_beat", 32'({y_last, y_data}), 32'(sb_a.pop_front()));
        end else begin
          check("sb_b_nonempty", 32'(sb_b.size() > 0), 32'd1);
          if (sb_b.size() > 0) check("sb_b_beat", 32'({y_last, y_data}), 32'(sb_b.pop_front()));
        end
        if (out_open) check("no_interleave", 32'(s), 32'(out_src));
        out_open <= !y_last;
        out_src  <= s;
      end
      if (a_valid && a_ready) sb_a.push_back({a_last, a_data});
      if (b_valid && b_ready) sb_b.push_back({b_last, b_data});
    end
  end

  // ---------------- helpers ----------------
  logic [9:0] exp_log[$];

  function automatic logic [9:0] bt(input bit src, input bit lst, input logic [7:0] d);
    return {src, lst, d};
  endfunction

  function automatic beat_t mk(input int gap, input logic [7:0] d, input bit lst);
    beat_t b;
    b.gap = 8'(gap); b.data = d; b.last = lst;
    return b;
  endfunction

  task automatic check_log(input string name, input bit contig);
    check({name, "_count"}, 32'(out_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++) begin
      check({name, "_beat"}, 32'(out_log[i]), 32'(exp_log[i]));
      if (contig) check({name, "_cycle"}, 32'(out_cyc[i] - out_cyc[0]), 32'(i));
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    y_ready = 1'b1;
    while ((qa.size() > 0 || qb.size() > 0 || a_valid || b_valid || y_valid) && c < 300) begin
      @(posedge clk); #2;
      c++;
    end
    check({name, "_drain"}, 32'(c < 300), 32'd1);
    check({name, "_sb_empty"}, 32'(sb_a.size() + sb_b.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; flush_req = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0; flush_req = 1'b0;
    out_log.delete(); out_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with both channels requesting, then alternating single-beat packets.
    y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(0, 8'h11, 1'b1));
      qb.push_back(mk(0, 8'h22, 1'b1));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_y_data",  32'(y_data),  32'd0);
    check("rst_s",       32'(s),       32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    out_log.delete(); out_cyc.delete();
    @(negedge clk);
    check("first_a_ready", 32'(a_ready), 32'd1);
    check("first_b_ready", 32'(b_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("alt_y_valid", 32'(y_valid), 32'd1);
      check("alt_s",       32'(s),       32'(k % 2));
      check("alt_y_data",  32'(y_data),  (k % 2 == 1) ? 32'h22 : 32'h11);
    end
    wait_drain("alt");
    exp_log.delete();
    for (int k = 0; k < 8; k++) exp_log.push_back((k % 2 == 1) ? bt(1, 1, 8'h22) : bt(0, 1, 8'h11));
    check_log("alt_log", 1'b1);

    // A 3-beat packet with B waiting; B follows without a gap.
    do_reset();
    qa.push_back(mk(0, 8'h01, 1'b0));
    qa.push_back(mk(0, 8'h02, 1'b0));
    qa.push_back(mk(0, 8'h03, 1'b1));
    qb.push_back(mk(0, 8'h33, 1'b1));
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lockA_a_ready", 32'(a_ready), 32'd1);
      check("lockA_b_ready", 32'(b_ready), 32'd0);
    end
    @(negedge clk);
    check("after_lockA_b_ready", 32'(b_ready), 32'd1);
    wait_drain("lockA");
    exp_log.delete();
    exp_log.push_back(bt(0, 0, 8'h01));
    exp_log.push_back(bt(0, 0, 8'h02));
    exp_log.push_back(bt(0, 1, 8'h03));
    exp_log.push_back(bt(1, 1, 8'h33));
    check_log("lockA_log", 1'b1);
    check("model_pref_after_lockA", 32'(m_pref), 32'd0);
    check("model_s_after_lockA", 32'(m_s), 32'd1);

    // Backpressure for 4 cycles in the middle of a packet.
    do_reset();
    for (int k = 0; k < 4; k++) qa.push_back(mk(0, 8'(8'h41 + k), k == 3));
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    y_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_y_valid", 32'(y_valid), 32'd1);
      check("stall_y_data",  32'(y_data),  32'h42);
      check("stall_y_last",  32'(y_last),  32'd0);
      check("stall_s",       32'(s),       32'd0);
      check("stall_a_ready", 32'(a_ready), 32'd0);
    end
    @(posedge clk); #2;
    y_ready = 1'b1;
    wait_drain("stall");
    exp_log.delete();
    for (int k = 0; k < 4; k++) exp_log.push_back(bt(0, k == 3, 8'(8'h41 + k)));
    check_log("stall_log", 1'b0);

    // Locked on B, B withdraws valid for 2 cycles while A waits.
    do_reset();
    qb.push_back(mk(0, 8'hB1, 1'b0));
    qb.push_back(mk(2, 8'hB2, 1'b0));
    qb.push_back(mk(0, 8'hB3, 1'b1));
    qa.push_back(mk(1, 8'hA1, 1'b1));
    @(posedge clk); #2;
    @(negedge clk);
    check("lockB_b_ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("lockB_gap_b_valid", 32'(b_valid), 32'd0);
      check("lockB_gap_a_ready", 32'(a_ready), 32'd0);
    end
    wait_drain("lockB");
    exp_log.delete();
    exp_log.push_back(bt(1, 0, 8'hB1));
    exp_log.push_back(bt(1, 0, 8'hB2));
    exp_log.push_back(bt(1, 1, 8'hB3));
    exp_log.push_back(bt(0, 1, 8'hA1));
    check_log("lockB_log", 1'b0);

    // Reset in the middle of an A packet, then only B requests.
    do_reset();
    qa.push_back(mk(0, 8'h61, 1'b0));
    qa.push_back(mk(0, 8'h62, 1'b0));
    qa.push_back(mk(0, 8'h63, 1'b1));
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("midrst_before_y_valid", 32'(y_valid), 32'd1);
    check("midrst_before_y_data",  32'(y_data),  32'h62);
    rst = 1'b1; flush_req = 1'b1;
    #1;
    check("midrst_async_y_valid", 32'(y_valid), 32'd0);
    check("midrst_async_y_data",  32'(y_data),  32'd0);
    check("midrst_async_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #3;
    qb.push_back(mk(0, 8'h77, 1'b1));
    rst = 1'b0; flush_req = 1'b0;
    out_log.delete(); out_cyc.delete();
    @(posedge clk); #2;
    @(negedge clk);
    check("midrst_b_ready", 32'(b_ready), 32'd1);
    check("midrst_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #2;
    check("midrst_y_data", 32'(y_data), 32'h77);
    check("midrst_s",      32'(s),      32'd1);
    wait_drain("midrst");

    // Randomized packets on both channels with random backpressure.
    do_reset();
    for (int p = 0; p < 30; p++) begin
      int la = $urandom_range(1, 4);
      int lb = $urandom_range(1, 4);
      for (int k = 0; k < la; k++)
        qa.push_back(mk($urandom_range(0, 2), 8'($urandom), k == la - 1));
      for (int k = 0; k < lb; k++)
        qb.push_back(mk($urandom_range(0, 2), 8'($urandom), k == lb - 1));
    end
    for (int c = 0; c < 6000 && (qa.size() > 0 || qb.size() > 0 || a_valid || b_valid); c++) begin
      @(posedge clk); #2;
      y_ready = ($urandom_range(0, 9) < 7);
    end
    wait_drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
